// File: rtl/cpu_pkg.sv
// cpu_pkg: shared branch/condition enums, ALU control codes and datapath defaults
package cpu_pkg;
  localparam int WIDTH_DEF = 64;
  localparam int REGW_DEF = 5;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_ORR = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  typedef enum logic [1:0] {BR_NONE, BR_COND, BR_CBZ, BR_CBNZ} br_kind_t;
  typedef enum logic [3:0] {
    C_EQ, C_NE, C_HS, C_LO, C_MI, C_PL, C_VS, C_VC,
    C_HI, C_LS, C_GE, C_LT, C_GT, C_LE, C_AL, C_NV
  } cond_t;
endpackage

// File: rtl/cond_eval.sv
// cond_eval: combinational B.cond evaluation from {N,Z,C,V}
module cond_eval
  import cpu_pkg::*;
(
  input  logic [3:0] nzcv_i,
  input  logic [3:0] cond_i,
  output logic       taken_o
);
  logic n, z, c, v;
  logic [7:0] base;
  assign {n, z, c, v} = nzcv_i;
  assign base = {1'b1, ~z & (n == v), n == v, c & ~z, v, n, c, z};
  // odd codes invert the even-code test, except AL/NV which are both always
  assign taken_o = (cond_i[0] && cond_i[3:1] != 3'b111) ? ~base[cond_i[3:1]] : base[cond_i[3:1]];
endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM pipeline register, NZCV flag register and branch resolution.
// Define EX_MEM_PERF_EN to build the stall/flush performance counters.
module ex_mem_stage
  import cpu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int REGW = REGW_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             ex_valid,
  input  logic [WIDTH-1:0] ex_result,
  input  logic             ex_negative,
  input  logic             ex_zero,
  input  logic             ex_overflow,
  input  logic             ex_carry_out,
  input  logic             ex_set_flags,
  input  logic             ex_vc_clear,
  input  logic [WIDTH-1:0] ex_store_data,
  input  logic [REGW-1:0]  ex_rd,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic             ex_mem_write,
  input  logic [1:0]       ex_br_kind,
  input  logic [3:0]       ex_cond,
  output logic             mem_valid,
  output logic [WIDTH-1:0] mem_result,
  output logic [WIDTH-1:0] mem_store_data,
  output logic [REGW-1:0]  mem_rd,
  output logic             mem_reg_write,
  output logic             mem_mem_read,
  output logic             mem_mem_write,
  output logic             mem_br_taken,
  output logic [3:0]       flags_nzcv,
  output logic [31:0]      perf_stall_cnt,
  output logic [31:0]      perf_flush_cnt
);
  logic ld, upd, cond_taken, taken_d;
  logic [3:0] flags_q, flags_d;
  br_kind_t kind;
  assign ld = ex_valid & ~stall & ~flush;
  assign upd = flush | ~stall;
  assign kind = br_kind_t'(ex_br_kind);
  cond_eval u_cond (.nzcv_i(flags_q), .cond_i(ex_cond), .taken_o(cond_taken));
  always_comb begin
    taken_d = kind == BR_CBZ ? ex_zero : kind == BR_CBNZ ? ~ex_zero : kind == BR_COND ? cond_taken : 1'b0;
    flags_d = (ld & ex_set_flags) ? {ex_negative, ex_zero, ex_carry_out & ~ex_vc_clear, ex_overflow & ~ex_vc_clear} : flags_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_valid <= 1'b0;
      mem_result <= '0;
      mem_store_data <= '0;
      mem_rd <= '0;
      mem_reg_write <= 1'b0;
      mem_mem_read <= 1'b0;
      mem_mem_write <= 1'b0;
      mem_br_taken <= 1'b0;
      flags_q <= 4'b0000;
    end else begin
      flags_q <= flags_d;
      if (upd) begin
        mem_valid <= ld;
        mem_result <= ex_result;
        mem_store_data <= ex_store_data;
        mem_rd <= ex_rd;
        mem_reg_write <= ld & ex_reg_write;
        mem_mem_read <= ld & ex_mem_read;
        mem_mem_write <= ld & ex_mem_write;
        mem_br_taken <= ld & taken_d;
      end
    end
  end
  assign flags_nzcv = flags_q;
`ifdef EX_MEM_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_q + {31'd0, stall};
      flush_cnt_q <= flush_cnt_q + {31'd0, flush};
    end
  end
  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif
endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: directed self-checking bench for ex_mem_stage
module tb_ex_mem_stage;
  logic clk = 0, reset, stall, flush, ex_valid;
  logic [63:0] ex_result, ex_store_data, mem_result, mem_store_data;
  logic ex_negative, ex_zero, ex_overflow, ex_carry_out, ex_set_flags, ex_vc_clear;
  logic [4:0] ex_rd, mem_rd;
  logic ex_reg_write, ex_mem_read, ex_mem_write;
  logic [1:0] ex_br_kind;
  logic [3:0] ex_cond, flags_nzcv;
  logic mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, mem_br_taken;
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
  int tests = 0, fails = 0;

  ex_mem_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .ex_valid(ex_valid),
    .ex_result(ex_result), .ex_negative(ex_negative), .ex_zero(ex_zero),
    .ex_overflow(ex_overflow), .ex_carry_out(ex_carry_out), .ex_set_flags(ex_set_flags),
    .ex_vc_clear(ex_vc_clear), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_br_kind(ex_br_kind), .ex_cond(ex_cond), .mem_valid(mem_valid),
    .mem_result(mem_result), .mem_store_data(mem_store_data), .mem_rd(mem_rd),
    .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .mem_br_taken(mem_br_taken), .flags_nzcv(flags_nzcv),
    .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    {stall, flush, ex_valid, ex_set_flags, ex_vc_clear} = '0;
    {ex_negative, ex_zero, ex_overflow, ex_carry_out} = '0;
    {ex_reg_write, ex_mem_read, ex_mem_write} = '0;
    ex_result = '0; ex_store_data = '0; ex_rd = '0; ex_br_kind = 2'b00; ex_cond = 4'h0;
  endtask

  // nzcv order: {N,Z,C,V}
  task automatic flag_op(input logic n, z, c, v, vcc);
    idle();
    ex_valid = 1; ex_set_flags = 1; ex_vc_clear = vcc;
    ex_negative = n; ex_zero = z; ex_carry_out = c; ex_overflow = v;
    step();
  endtask

  task automatic branch(input logic [1:0] kind, input logic [3:0] cond, input logic z);
    idle();
    ex_valid = 1; ex_br_kind = kind; ex_cond = cond; ex_zero = z;
    step();
  endtask

  logic [31:0] exp_stall;

  initial begin
    idle();
    reset = 1;
    step(); step();
    reset = 0;
    step();
    check("rst_valid", mem_valid, 0);
    check("rst_result", mem_result, 0);
    check("rst_rd", mem_rd, 0);
    check("rst_br", mem_br_taken, 0);
    check("rst_flags", flags_nzcv, 4'b0000);
    check("rst_pstall", perf_stall_cnt, 0);
    check("rst_pflush", perf_flush_cnt, 0);

    ex_valid = 1; ex_result = 64'h5; ex_rd = 5'd3; ex_reg_write = 1; ex_store_data = 64'hDEAD; ex_mem_write = 1;
    step();
    check("ld_result", mem_result, 64'h5);
    check("ld_rd", mem_rd, 3);
    check("ld_valid", mem_valid, 1);
    check("ld_rw", mem_reg_write, 1);
    check("ld_sd", mem_store_data, 64'hDEAD);
    check("ld_mw", mem_mem_write, 1);

    flag_op(0, 1, 1, 1, 0);
    check("adds_flags", flags_nzcv, 4'b0111);
    branch(2'b01, 4'h0, 0);
    check("beq_taken", mem_br_taken, 1);
    check("beq_flags", flags_nzcv, 4'b0111);
    flag_op(0, 1, 1, 1, 0);
    branch(2'b01, 4'h1, 0);
    check("bne_taken", mem_br_taken, 0);

    flag_op(1, 0, 1, 1, 1);
    check("ands_flags", flags_nzcv, 4'b1000);
    branch(2'b01, 4'hB, 0);
    check("blt_taken", mem_br_taken, 1);
    branch(2'b01, 4'hC, 0);
    check("bgt_taken", mem_br_taken, 0);
    branch(2'b01, 4'hF, 0);
    check("bnv_taken", mem_br_taken, 1);

    branch(2'b10, 4'h0, 1);
    check("cbz_taken", mem_br_taken, 1);
    branch(2'b11, 4'h0, 1);
    check("cbnz_z1", mem_br_taken, 0);
    branch(2'b11, 4'h0, 0);
    check("cbnz_z0", mem_br_taken, 1);

    idle();
    ex_valid = 1; ex_result = 64'hAA; ex_rd = 5'd7; ex_reg_write = 1; ex_br_kind = 2'b10; ex_zero = 1;
    step();
    flag_op(0, 0, 0, 0, 0);
    check("pre_stall_flags", flags_nzcv, 4'b0000);
    idle();
    ex_valid = 1; ex_result = 64'hAA; ex_rd = 5'd7; ex_reg_write = 1; ex_br_kind = 2'b10; ex_zero = 1;
    step();
    flag_op(1, 0, 1, 0, 0);
    check("pre_stall_f2", flags_nzcv, 4'b1010);
    idle();
    ex_valid = 1; ex_result = 64'hAA; ex_rd = 5'd7; ex_reg_write = 1; ex_br_kind = 2'b10; ex_zero = 1;
    step();
    idle();
    stall = 1; ex_valid = 1; ex_result = 64'h1234; ex_rd = 5'd9; ex_set_flags = 1;
    ex_negative = 0; ex_zero = 1; ex_carry_out = 0; ex_overflow = 1;
    step(); step(); step();
    check("stall_result", mem_result, 64'hAA);
    check("stall_rd", mem_rd, 7);
    check("stall_br", mem_br_taken, 1);
    check("stall_valid", mem_valid, 1);
    check("stall_flags", flags_nzcv, 4'b1010);
`ifdef EX_MEM_PERF_EN
    exp_stall = 32'd3;
`else
    exp_stall = 32'd0;
`endif
    check("stall_cnt", perf_stall_cnt, exp_stall);
    stall = 0;
    step();
    check("unstall_result", mem_result, 64'h1234);
    check("unstall_flags", flags_nzcv, 4'b0101);
    check("unstall_br", mem_br_taken, 0);

    idle();
    stall = 1; flush = 1; ex_valid = 1; ex_set_flags = 1; ex_reg_write = 1; ex_br_kind = 2'b10;
    ex_negative = 1; ex_zero = 1; ex_carry_out = 1; ex_overflow = 1;
    step();
    check("flush_valid", mem_valid, 0);
    check("flush_rw", mem_reg_write, 0);
    check("flush_br", mem_br_taken, 0);
    check("flush_flags", flags_nzcv, 4'b0101);
`ifdef EX_MEM_PERF_EN
    check("flush_cnt", perf_flush_cnt, 1);
    check("stall_cnt4", perf_stall_cnt, 4);
`else
    check("flush_cnt", perf_flush_cnt, 0);
`endif

    idle();
    ex_valid = 1; ex_rd = 5'd2; ex_reg_write = 1; ex_mem_read = 1;
    step();
    check("lw_rd", mem_mem_read, 1);
    ex_valid = 0;
    step();
    check("bubble_valid", mem_valid, 0);
    check("bubble_mr", mem_mem_read, 0);
    check("bubble_rw", mem_reg_write, 0);

    idle();
    ex_valid = 1; ex_result = 64'h77; ex_reg_write = 1;
    step();
    stall = 1;
    step();
    reset = 1;
    step();
    reset = 0; stall = 0; ex_valid = 0;
    check("rst_mid_valid", mem_valid, 0);
    check("rst_mid_result", mem_result, 0);
    check("rst_mid_flags", flags_nzcv, 4'b0000);
    check("rst_mid_pstall", perf_stall_cnt, 0);

`ifdef EX_MEM_PERF_EN
    force dut.stall_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt_q;
    stall = 1;
    step();
    stall = 0;
    check("wrap_cnt", perf_stall_cnt, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
